// File: rtl/html_tokenizer.sv
// html_tokenizer: turns the reader's character stream into OPEN/CLOSE/ATTR/
// TEXT/END tokens held in a single-entry output register with valid/ready.
module html_tokenizer #(
    parameter int NAME_CHARS = 6
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    state_enable,
    input  logic [7:0]              char,
    input  logic                    in_finished,
    output logic                    pause,
    output logic                    tok_valid,
    input  logic                    tok_ready,
    output logic [2:0]              tok_type,
    output logic [8*NAME_CHARS-1:0] tok_name,
    output logic [7:0]              tok_value,
    output logic                    parse_error,
    output logic                    done
);
    localparam int LEN_W = $clog2(NAME_CHARS + 1);
    localparam int NW    = 8 * NAME_CHARS;

    localparam logic [3:0] S_DATA       = 4'd0;
    localparam logic [3:0] S_TAG_START  = 4'd1;
    localparam logic [3:0] S_TAG_NAME   = 4'd2;
    localparam logic [3:0] S_CLOSE_NAME = 4'd3;
    localparam logic [3:0] S_IN_TAG     = 4'd4;
    localparam logic [3:0] S_ATTR_NAME  = 4'd5;
    localparam logic [3:0] S_ATTR_VALUE = 4'd6;
    localparam logic [3:0] S_FLUSH      = 4'd7;
    localparam logic [3:0] S_DONE       = 4'd8;

    localparam logic [2:0] T_OPEN  = 3'd0;
    localparam logic [2:0] T_CLOSE = 3'd1;
    localparam logic [2:0] T_ATTR  = 3'd2;
    localparam logic [2:0] T_TEXT  = 3'd3;
    localparam logic [2:0] T_END   = 3'd4;

    logic [3:0]       r_state;
    logic [NW-1:0]    r_name;
    logic [LEN_W-1:0] r_len;
    logic [7:0]       r_val;
    logic             r_tok_valid;
    logic [2:0]       r_tok_type;
    logic [NW-1:0]    r_tok_name;
    logic [7:0]       r_tok_value;
    logic             r_err;
    logic             r_done;

    logic             w_consume, w_free, w_letter, w_digit;
    logic [NW-1:0]    w_app_name, w_first_name;
    logic [LEN_W-1:0] w_app_len;
    logic [11:0]      w_prod;
    logic [3:0]       w_nstate;
    logic [NW-1:0]    w_nname;
    logic [LEN_W-1:0] w_nlen;
    logic [7:0]       w_nval;
    logic             w_err, w_emit;
    logic [2:0]       w_etype;
    logic [NW-1:0]    w_ename;
    logic [7:0]       w_evalue;

    assign pause       = r_tok_valid & ~tok_ready;
    assign w_free      = ~r_tok_valid | tok_ready;
    assign w_consume   = state_enable & ~pause & ~in_finished & (char != 8'd0);
    assign w_letter    = (char >= "a" && char <= "z") || (char >= "A" && char <= "Z");
    assign w_digit     = (char >= "0" && char <= "9");
    assign w_prod      = 12'(r_val) * 12'd10 + {8'd0, char[3:0]};
    assign w_app_len   = (r_len < LEN_W'(NAME_CHARS)) ? r_len + LEN_W'(1) : r_len;

    assign tok_valid   = r_tok_valid;
    assign tok_type    = r_tok_type;
    assign tok_name    = r_tok_name;
    assign tok_value   = r_tok_value;
    assign parse_error = r_err;
    assign done        = r_done;

    // Name buffer candidates: current name with char appended (dropped once full),
    // and a fresh name that starts with char; first char sits in the top byte.
    always_comb begin
        w_app_name   = r_name;
        w_first_name = '0;
        w_first_name[NW-1 -: 8] = char;
        for (int i = 0; i < NAME_CHARS; i++)
            if (r_len == LEN_W'(i)) w_app_name[8*(NAME_CHARS-1-i) +: 8] = char;
    end

    // Parser next-state: at most one token per consumed character, then end-of-input handling.
    always_comb begin
        w_nstate = r_state;
        w_nname  = r_name;
        w_nlen   = r_len;
        w_nval   = r_val;
        w_err    = 1'b0;
        w_emit   = 1'b0;
        w_etype  = T_OPEN;
        w_ename  = '0;
        w_evalue = 8'd0;
        if (w_consume) begin
            case (r_state)
                S_DATA: begin
                    if (char == "<") w_nstate = S_TAG_START;
                    else begin w_emit = 1'b1; w_etype = T_TEXT; w_evalue = char; end
                end
                S_TAG_START: begin
                    if (char == "/") begin
                        w_nstate = S_CLOSE_NAME; w_nname = '0; w_nlen = '0;
                    end else if (w_letter) begin
                        w_nstate = S_TAG_NAME; w_nname = w_first_name; w_nlen = LEN_W'(1);
                    end else begin
                        w_err = 1'b1; w_nstate = S_DATA;
                    end
                end
                S_TAG_NAME, S_CLOSE_NAME: begin
                    if (w_letter || w_digit) begin
                        w_nname = w_app_name; w_nlen = w_app_len;
                    end else if (char == ">") begin
                        w_emit   = 1'b1; w_ename = r_name; w_nstate = S_DATA;
                        w_etype  = (r_state == S_TAG_NAME) ? T_OPEN : T_CLOSE;
                    end else if (char == " " && r_state == S_TAG_NAME) begin
                        w_emit = 1'b1; w_ename = r_name; w_etype = T_OPEN; w_nstate = S_IN_TAG;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                S_IN_TAG: begin
                    if (w_letter) begin
                        w_nstate = S_ATTR_NAME; w_nname = w_first_name; w_nlen = LEN_W'(1);
                    end else if (char == ">") w_nstate = S_DATA;
                    else if (char != " ") w_err = 1'b1;
                end
                S_ATTR_NAME: begin
                    if (char == "=") begin
                        w_nstate = S_ATTR_VALUE; w_nval = 8'd0;
                    end else if (char == " " || char == ">") begin
                        w_emit   = 1'b1; w_etype = T_ATTR; w_ename = r_name;
                        w_nstate = (char == ">") ? S_DATA : S_IN_TAG;
                    end else begin
                        w_nname = w_app_name; w_nlen = w_app_len;
                    end
                end
                S_ATTR_VALUE: begin
                    if (w_digit) begin
                        w_nval = (w_prod > 12'd255) ? 8'hFF : w_prod[7:0];
                    end else if (char == " " || char == ">") begin
                        w_emit   = 1'b1; w_etype = T_ATTR; w_ename = r_name; w_evalue = r_val;
                        w_nstate = (char == ">") ? S_DATA : S_IN_TAG;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (state_enable && in_finished && r_state != S_FLUSH && r_state != S_DONE) begin
            w_nstate = S_FLUSH;
            w_err    = (r_state != S_DATA);
        end else if (r_state == S_FLUSH && w_free) begin
            w_emit   = 1'b1; w_etype = T_END; w_nstate = S_DONE;
        end
    end

    // State, name buffer, token register and status flags; state_enable low clears all.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn || !state_enable) begin
            r_state     <= S_DATA;
            r_name      <= '0;
            r_len       <= '0;
            r_val       <= 8'd0;
            r_tok_valid <= 1'b0;
            r_tok_type  <= 3'd0;
            r_tok_name  <= '0;
            r_tok_value <= 8'd0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_name  <= w_nname;
            r_len   <= w_nlen;
            r_val   <= w_nval;
            if (w_err) r_err <= 1'b1;
            if (r_tok_valid && tok_ready && r_tok_type == T_END) r_done <= 1'b1;
            if (w_emit) begin
                r_tok_valid <= 1'b1;
                r_tok_type  <= w_etype;
                r_tok_name  <= w_ename;
                r_tok_value <= w_evalue;
            end else if (tok_ready) begin
                r_tok_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_html_tokenizer.sv
// Directed bench for html_tokenizer: a reader model feeds strings, accepted
// tokens are collected and compared with hand-written expected sequences.
module tb_html_tokenizer;
    logic        clock = 0, resetn = 0, state_enable = 1, in_finished = 0, tok_ready = 1;
    logic [7:0]  char = 0;
    logic        pause, tok_valid, parse_error, done;
    logic [2:0]  tok_type;
    logic [47:0] tok_name;
    logic [7:0]  tok_value;

    typedef struct packed { logic [2:0] t; logic [47:0] n; logic [7:0] v; } tok_t;
    tok_t toks[$];
    int   n_chk = 0, n_pass = 0, n_fail = 0, idx = 0;
    string full = "<body><p color=1 size=2 >test</p></body>";

    html_tokenizer #(.NAME_CHARS(6)) dut (
        .clock(clock), .resetn(resetn), .state_enable(state_enable), .char(char),
        .in_finished(in_finished), .pause(pause), .tok_valid(tok_valid), .tok_ready(tok_ready),
        .tok_type(tok_type), .tok_name(tok_name), .tok_value(tok_value),
        .parse_error(parse_error), .done(done));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin n_fail++; $error("FAIL %s: got %0h expected %0h", tag, obs, exp); end
    endtask

    function automatic logic [47:0] nm(input string s);
        logic [47:0] r = '0;
        for (int i = 0; i < 6 && i < s.len(); i++) r[47-8*i -: 8] = s[i];
        return r;
    endfunction

    task automatic tk(input int k, input logic [2:0] t, input logic [47:0] n, input logic [7:0] v);
        check($sformatf("tok%0d_present", k), 64'(toks.size() > k), 64'd1);
        if (toks.size() > k) begin
            check($sformatf("tok%0d_type", k), 64'(toks[k].t), 64'(t));
            check($sformatf("tok%0d_name", k), 64'(toks[k].n), 64'(n));
            check($sformatf("tok%0d_value", k), 64'(toks[k].v), 64'(v));
        end
    endtask

    // mode 0: ready=1, 1: ready toggles, 2: ready=0. fin: raise in_finished and run until done.
    task automatic run(input string s, input int mode, input bit fin, input int extra);
        int cyc = 0, ext = extra;
        bit go, prev_stall = 0;
        tok_t prev;
        idx = 0;
        toks.delete();
        tok_ready = (mode != 2);
        while (1) begin
            @(negedge clock);
            tok_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ~tok_ready : 1'b0;
            if (idx < s.len()) begin char = s[idx]; in_finished = 0; end
            else begin char = 0; in_finished = fin; end
            #1;
            if (fin && done) break;
            if (!fin && idx >= s.len()) begin
                if (ext == 0) break;
                ext--;
            end
            check("pause_rel", 64'(pause), 64'(tok_valid & ~tok_ready));
            if (prev_stall) begin
                check("stall_valid", 64'(tok_valid), 64'd1);
                check("stall_hold", 64'({tok_type, tok_name, tok_value}), 64'(prev));
            end
            prev_stall = tok_valid & ~tok_ready;
            prev = '{tok_type, tok_name, tok_value};
            if (tok_valid && tok_ready) toks.push_back('{tok_type, tok_name, tok_value});
            go = !pause && char != 0 && !in_finished;
            @(posedge clock);
            if (go) idx++;
            if (++cyc > 400) begin
                n_chk++; n_fail++;
                $error("FAIL timeout: got %0d cycles expected at most 400", cyc);
                break;
            end
        end
        char = 0; in_finished = 0; tok_ready = 1;
    endtask

    task automatic clear();
        @(negedge clock); state_enable = 0; char = 0; in_finished = 0;
        @(negedge clock); state_enable = 1;
    endtask

    task automatic exp_full();
        check("full_count", 64'(toks.size()), 64'd11);
        tk(0, 3'd0, 48'h626F64790000, 8'd0);
        tk(1, 3'd0, nm("p"), 8'd0);
        tk(2, 3'd2, nm("color"), 8'd1);
        tk(3, 3'd2, nm("size"), 8'd2);
        tk(4, 3'd3, 48'd0, "t");
        tk(5, 3'd3, 48'd0, "e");
        tk(6, 3'd3, 48'd0, "s");
        tk(7, 3'd3, 48'd0, "t");
        tk(8, 3'd1, nm("p"), 8'd0);
        tk(9, 3'd1, nm("body"), 8'd0);
        tk(10, 3'd4, 48'd0, 8'd0);
        check("full_consumed", 64'(idx), 64'(full.len()));
        check("full_perr", 64'(parse_error), 64'd0);
        check("full_done", 64'(done), 64'd1);
    endtask

    initial begin
        #2;
        check("rst_outs", 64'({tok_valid, tok_type, tok_name, tok_value, parse_error, done, pause}), 64'd0);
        @(negedge clock); resetn = 1;

        run(full, 0, 1, 0);
        exp_full();

        clear();
        run(full, 1, 1, 0);
        exp_full();

        clear();
        run("<p w=300>", 0, 0, 3);
        check("sat_count", 64'(toks.size()), 64'd2);
        tk(0, 3'd0, nm("p"), 8'd0);
        tk(1, 3'd2, nm("w"), 8'd255);

        clear();
        run("<p w=12>", 0, 0, 3);
        tk(1, 3'd2, nm("w"), 8'd12);
        check("w12_perr", 64'(parse_error), 64'd0);

        clear();
        run("<abcdefgh>", 0, 0, 3);
        check("trunc_count", 64'(toks.size()), 64'd1);
        tk(0, 3'd0, nm("abcdef"), 8'd0);
        check("trunc_perr", 64'(parse_error), 64'd0);

        clear();
        run("<p=>", 0, 0, 3);
        check("eq_count", 64'(toks.size()), 64'd1);
        tk(0, 3'd0, nm("p"), 8'd0);
        check("eq_perr", 64'(parse_error), 64'd1);

        clear();
        run("<p w=5", 0, 1, 0);
        check("eof_count", 64'(toks.size()), 64'd2);
        tk(0, 3'd0, nm("p"), 8'd0);
        tk(1, 3'd4, 48'd0, 8'd0);
        check("eof_perr", 64'(parse_error), 64'd1);
        check("eof_done", 64'(done), 64'd1);
        clear();
        #1;
        check("clr_outs", 64'({tok_valid, tok_type, tok_name, tok_value, parse_error, done, pause}), 64'd0);

        run("x", 2, 0, 3);
        check("pre_rst_valid", 64'(tok_valid), 64'd1);
        resetn = 0;
        #1;
        check("async_rst_valid", 64'(tok_valid), 64'd0);
        check("async_rst_tok", 64'({tok_type, tok_value}), 64'd0);
        @(negedge clock); resetn = 1;
        run("y", 0, 0, 3);
        check("post_rst_count", 64'(toks.size()), 64'd1);
        tk(0, 3'd3, 48'd0, "y");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
